// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and
// mid-bit sampling. Emits a one-cycle axiov strobe with the received byte.
// Optional feature macro: UART_RX_FRAMING_ERR_EN adds a framing_err pulse
// output that fires when the stop-bit sample is 0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiid,
  output logic       axiov,
  output logic [7:0] axiod
`ifdef UART_RX_FRAMING_ERR_EN
  ,
  output logic       framing_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  // BREAK holds off after a bad stop bit until the line goes high again,
  // so a held-low break is not mistaken for a new start bit.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          axiov_q, axiov_d;
  logic [7:0]    axiod_q, axiod_d;
`ifdef UART_RX_FRAMING_ERR_EN
  logic          ferr_q, ferr_d;
`endif

  logic rx_s;
  assign rx_s = sync2_q;

  // Register all state; low rst at a clock edge restores idle values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
`ifdef UART_RX_FRAMING_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
`ifdef UART_RX_FRAMING_ERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  // Next-state logic: synchronizer shift, bit timing, byte assembly.
  always_comb begin
    state_d = state_q;
    sync1_d = axiid;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    axiov_d = 1'b0;
    axiod_d = axiod_q;
`ifdef UART_RX_FRAMING_ERR_EN
    ferr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          shift_d[idx_q] = rx_s;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            axiov_d = 1'b1;
            axiod_d = shift_q;
            state_d = IDLE;
          end else begin
`ifdef UART_RX_FRAMING_ERR_EN
            ferr_d = 1'b1;
`endif
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
`ifdef UART_RX_FRAMING_ERR_EN
  assign framing_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx using a short bit period so that many
// frames fit in a quick run. Directed frames with hand-computed results.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clock;
   logic       rst;
   logic       axiid;
   logic       axiov;
   logic [7:0] axiod;
`ifdef UART_RX_FRAMING_ERR_EN
   logic       framing_err;
`endif

   int checks = 0;
   int failures = 0;
   int pulseCount = 0;
   int doubleHigh = 0;
   int ferrCount = 0;
   int cycle = 0;
   int firstPulseCycle = -1;
   logic prevValid = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clock),
      .rst(rst),
      .axiid(axiid),
      .axiov(axiov),
      .axiod(axiod)
`ifdef UART_RX_FRAMING_ERR_EN
      ,
      .framing_err(framing_err)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watch the strobe on the falling edge: count pulses, catch back-to-back highs.
   always @(negedge clock) begin
      cycle = cycle + 1;
      if (axiov === 1'b1) begin
         pulseCount = pulseCount + 1;
         if (firstPulseCycle < 0) firstPulseCycle = cycle;
         if (prevValid) doubleHigh = doubleHigh + 1;
      end
      prevValid = (axiov === 1'b1);
`ifdef UART_RX_FRAMING_ERR_EN
      if (framing_err === 1'b1) ferrCount = ferrCount + 1;
`endif
   end

   // Compare one observed value against its expected value and tally.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (observed !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Drive one 8N1 frame on the line; stopBit lets a bad stop be forced.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      axiid = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         axiid = data[i];
         waitCycles(CPB);
      end
      axiid = stopBit;
      waitCycles(CPB);
      axiid = 1'b1;
   endtask

   // Directed sequence of frames and line conditions.
   initial begin
      int startCycle;
      rst = 1'b0;
      axiid = 1'b1;
      waitCycles(4);
      checkOutput("reset_axiov", {31'd0, axiov}, 32'd0);
      checkOutput("reset_axiod", {24'd0, axiod}, 32'h00);
      rst = 1'b1;

      waitCycles(2 * CPB);
      checkOutput("idle_no_pulse", pulseCount, 0);
      checkOutput("idle_axiod", {24'd0, axiod}, 32'h00);

      startCycle = cycle + 1;
      applyStimulus(8'hAA, 1'b1);
      waitCycles(CPB);
      checkOutput("aa_pulses", pulseCount, 1);
      checkOutput("aa_data", {24'd0, axiod}, 32'hAA);
      checkOutput("aa_latency_window",
                  {31'd0, (firstPulseCycle - startCycle >= 150) &&
                          (firstPulseCycle - startCycle <= 160)}, 32'd1);
      waitCycles(3 * CPB);
      checkOutput("aa_hold", {24'd0, axiod}, 32'hAA);

      // Back-to-back frames with a 0.4-bit idle gap between them.
      applyStimulus(8'hAA, 1'b1);
      waitCycles(CPB * 4 / 10);
      applyStimulus(8'hCC, 1'b1);
      waitCycles(CPB);
      checkOutput("cc_pulses", pulseCount, 3);
      checkOutput("cc_data", {24'd0, axiod}, 32'hCC);

      // Short low glitch must not start a frame.
      axiid = 1'b0;
      waitCycles(CPB / 4);
      axiid = 1'b1;
      waitCycles(3 * CPB);
      checkOutput("glitch_no_pulse", pulseCount, 3);
      checkOutput("glitch_data_kept", {24'd0, axiod}, 32'hCC);
      applyStimulus(8'h55, 1'b1);
      waitCycles(CPB);
      checkOutput("after_glitch_pulses", pulseCount, 4);
      checkOutput("after_glitch_data", {24'd0, axiod}, 32'h55);

      // Stop bit held low: frame is dropped.
      applyStimulus(8'h3C, 1'b0);
      waitCycles(2 * CPB);
      checkOutput("ferr_no_pulse", pulseCount, 4);
      checkOutput("ferr_data_kept", {24'd0, axiod}, 32'h55);
`ifdef UART_RX_FRAMING_ERR_EN
      checkOutput("ferr_pulse_count", ferrCount, 1);
`endif

      // Reset in the middle of data bit 4 aborts the frame.
      axiid = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 4; i++) begin
         axiid = (8'h3C >> i) & 1'b1;
         waitCycles(CPB);
      end
      axiid = 1'b1;
      waitCycles(CPB / 2);
      rst = 1'b0;
      waitCycles(2);
      rst = 1'b1;
      waitCycles(12 * CPB);
      checkOutput("midreset_no_pulse", pulseCount, 4);
      checkOutput("midreset_axiod", {24'd0, axiod}, 32'h00);
      applyStimulus(8'h81, 1'b1);
      waitCycles(CPB);
      checkOutput("post_reset_pulses", pulseCount, 5);
      checkOutput("post_reset_data", {24'd0, axiod}, 32'h81);

      checkOutput("single_cycle_strobe", doubleHigh, 0);
`ifndef UART_RX_FRAMING_ERR_EN
      checkOutput("ferr_unused", ferrCount, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: samples serial line `axiid`, reassembles one byte per frame, pulses a one-cycle valid strobe with the byte.
- Sits between the board's serial RX pin and the byte-consuming logic (command/puzzle loader).
- Single clock domain; `axiid` is asynchronous to `clk` and is synchronized internally.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); must be >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 sampled at a rising edge resets).
- axiid  input  1  serial line, idle high, asynchronous.
- axiov  output  1  one-cycle pulse: axiod holds a newly received byte.
- axiod  output  8  received byte; holds its value until the next good frame.

Behaviour:
- Reset values: axiov=0, axiod=8'h00, state=IDLE, counters=0, synchronizer flops=1 (idle).
- Synchronizer: 2-flop chain on axiid; all decisions use the second flop output (rx_s).
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
- States:
  - IDLE: wait for rx_s==0 → START, clear the cycle counter.
  - START: count to (CLKS_PER_BIT-1)/2 (mid-bit). At mid-bit:
    - if rx_s==0 → DATA, clear counter, bit index=0;
    - else glitch → IDLE.
  - DATA: count CLKS_PER_BIT-1 cycles per bit, then sample rx_s into shift register bit[index]. After index 7 → STOP.
  - STOP: after CLKS_PER_BIT-1 cycles (mid stop bit), sample rx_s:
    - if 1: load axiod with the assembled byte, axiov=1 for exactly one cycle, → IDLE;
    - if 0: framing error; discard byte, axiov stays 0, axiod unchanged, → IDLE (only after rx_s returns high, to avoid re-triggering on a break).
- Return to IDLE at mid stop bit, so a back-to-back start bit is never missed.
- Latency: axiov rises about 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after the falling edge of the start bit.
- Reset mid-frame: abort immediately; no axiov; outputs return to reset values.
- axiov is never high for two consecutive cycles.
- No backpressure; the consumer must capture axiod on the axiov cycle or while it is held.
- Tolerance: sampling at mid-bit accepts baud mismatch up to about ±4% over a frame.

Optional Feature:
- Macro UART_RX_FRAMING_ERR_EN.
- Defined: adds output port `framing_err` (1 bit, reset 0), pulsed high for one cycle when the stop-bit sample is 0 (same cycle axiov would have fired).
- Not defined: port absent; bad frames are silently dropped.
- Core receive behaviour is identical either way.

Test Plan:
- Reset, then hold axiid=1 for 2*CLKS_PER_BIT cycles → axiov never asserts, axiod=8'h00.
- Send frame 0xAA (line sequence 0,0,1,0,1,0,1,0,1,1 at CLKS_PER_BIT=10417) → single one-cycle axiov pulse, axiod=8'hAA, and axiod holds afterwards.
- Send 0xCC (line sequence 0,0,0,1,1,0,0,1,1,1) right after 0xAA with a 0.4-bit idle gap → second pulse, axiod=8'hCC.
- Start-bit glitch: axiid low for CLKS_PER_BIT/4 cycles, then high → no axiov, receiver back in IDLE; a following valid 0x55 frame is received correctly.
- Stop bit forced 0 on a 0x3C frame → no axiov, axiod keeps its previous value; with UART_RX_FRAMING_ERR_EN, framing_err pulses once.
- Assert rst=0 during data bit 4 of a frame → no axiov for that frame, axiod=8'h00; the next full frame 0x81 is received correctly.
